// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes, legal-op helper and arbiter FSM state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b0111;
    localparam logic [3:0] ALU_SLT = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic op_legal(input logic [3:0] op);
        logic ok;
        case (op)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
            ALU_XOR, ALU_NOR, ALU_SLT: ok = 1'b1;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response channels of the shared ALU plus the ALU drive/return bus.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the request and the response channel.
interface alu_arbiter_if #(
    parameter int NREQ = 2,
    parameter int W    = 32
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_op;
    logic [W*NREQ-1:0] req_a;
    logic [W*NREQ-1:0] req_b;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [W-1:0]      rsp_res;
    logic              rsp_zero;
    logic              rsp_err;
    logic [3:0]        alu_op;
    logic [W-1:0]      alu_a;
    logic [W-1:0]      alu_b;
    logic [W-1:0]      alu_res;
    logic              alu_zero;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_res, rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready, alu_res, alu_zero,
        output req_ready, rsp_valid, rsp_res, rsp_zero, rsp_err, alu_op, alu_a, alu_b
    );

    modport alu (
        input  alu_op, alu_a, alu_b,
        output alu_res, alu_zero
    );

endinterface

// File: rtl/alu_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin pick of one requester, search starting at ptr and wrapping.
// Latency: combinational.
// Backpressure: none; grant is zero when no request is set.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx,
    output logic            gnt_vld
);

    logic [NREQ-1:0] rot;
    logic [IW:0]     sum;

    // Rotate so bit 0 is the pointer position; the lowest set bit wins.
    always_comb begin
        rot     = NREQ'({req, req} >> ptr);
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        sum     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                gnt_vld = 1'b1;
                sum     = {1'b0, ptr} + (IW+1)'(k);
            end
        end
        if (sum >= (IW+1)'(NREQ)) begin
            sum = sum - (IW+1)'(NREQ);
        end
        gnt_idx = sum[IW-1:0];
        if (gnt_vld) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one ALU by NREQ requesters; ALU_ARB_ILLEGAL_OP_CHK_EN suppresses illegal ops.
// Latency: request handshake in cycle N -> rsp_valid in cycle N+2; one op in flight, 3 cycles min per op.
// Backpressure: response held until the owner's rsp_ready; req_ready low while EXEC/RESP.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);

    localparam int IW = $clog2(NREQ);

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [3:0]      op_q, op_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    res_q, res_d;
    logic            zero_q, zero_d;
`ifdef ALU_ARB_ILLEGAL_OP_CHK_EN
    logic            ill_q, ill_d;
    logic            err_q, err_d;
`endif

    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_vld;
    logic [3:0]      sel_op;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;
    logic [NREQ-1:0] rsp_vld;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .req     (bus.req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_op = bus.req_op[4*i +: 4];
                sel_a  = bus.req_a[W*i +: W];
                sel_b  = bus.req_b[W*i +: W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        zero_d  = zero_q;
`ifdef ALU_ARB_ILLEGAL_OP_CHK_EN
        ill_d   = ill_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    state_d = ST_EXEC;
                    owner_d = gnt_idx;
                    ptr_d   = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                    op_d    = sel_op;
                    a_d     = sel_a;
                    b_d     = sel_b;
`ifdef ALU_ARB_ILLEGAL_OP_CHK_EN
                    // Illegal ops are accepted but the ALU only sees a harmless ADD 0+0.
                    ill_d = !op_legal(sel_op);
                    if (!op_legal(sel_op)) begin
                        op_d = ALU_ADD;
                        a_d  = '0;
                        b_d  = '0;
                    end
`endif
                end
            end
            ST_EXEC: begin
                res_d   = bus.alu_res;
                zero_d  = bus.alu_zero;
                state_d = ST_RESP;
`ifdef ALU_ARB_ILLEGAL_OP_CHK_EN
                err_d = ill_q;
                if (ill_q) begin
                    res_d  = '0;
                    zero_d = 1'b1;
                end
`endif
            end
            ST_RESP: begin
                if (bus.rsp_ready[owner_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
`ifdef ALU_ARB_ILLEGAL_OP_CHK_EN
            ill_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
`ifdef ALU_ARB_ILLEGAL_OP_CHK_EN
            ill_q   <= ill_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        rsp_vld = '0;
        if (state_q == ST_RESP) begin
            rsp_vld[owner_q] = 1'b1;
        end
    end

    // Gated by rst_n so no grant escapes while reset is held.
    assign bus.req_ready = (state_q == ST_IDLE && rst_n) ? gnt : '0;
    assign bus.rsp_valid = rsp_vld;
    assign bus.rsp_res   = res_q;
    assign bus.rsp_zero  = zero_q;
    assign bus.alu_op    = op_q;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
`ifdef ALU_ARB_ILLEGAL_OP_CHK_EN
    assign bus.rsp_err   = err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif

endmodule
